// File: rtl/pc_ir_unit_pkg.sv
// Shared encodings and field bounds for the multicycle fetch-side registers.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package pc_ir_unit_pkg;

  // Next-PC source select encodings driven by the main decoder
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  // Instruction field bounds
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int JMP_HI = 25;
  localparam int JMP_LO = 0;

  localparam int OP_W  = OP_HI - OP_LO + 1;
  localparam int JMP_W = JMP_HI - JMP_LO + 1;

  // Default PC after reset (word aligned)
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Jump target: upper nibble of the current PC, 26-bit field, word offset
  function automatic logic [31:0] jump_target(input logic [31:0] cur_pc,
                                              input logic [31:0] cur_instr);
    return {cur_pc[31:28], cur_instr[JMP_HI:JMP_LO], 2'b00};
  endfunction

endpackage

// File: rtl/pc_ir_unit_flopenr.sv
// Enable flop of parameterised width with asynchronous active-high reset value.
// Latency: one clock from d/en to q.
// Backpressure: none; en simply holds the current value.
module flopenr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d on enabled edges; reset forces the reset value immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR / MDR / ALUOut holder for the multicycle core; optional perf counters (PC_IR_PERF_COUNT_EN).
// Latency: one clock from enable to register output; memaddr/op combinational from registers.
// Backpressure: none; single-cycle memory, no handshake.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcwrite,
  input  logic             pcwritecond,
  input  logic             iord,
  input  logic             irwrite,
  input  logic [1:0]       pcsrc,
  input  logic             zero,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] memrdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] memaddr,
  output logic [WIDTH-1:0] instr,
  output logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] mdr,
  output logic [WIDTH-1:0] aluout,
  output logic [31:0]      cycle_count,
  output logic [31:0]      instr_count
);

  logic             pcen;
  logic [WIDTH-1:0] pcnext;
  logic [WIDTH-1:0] pcsel;

  // Next-PC select; the reserved encoding suppresses the write entirely
  always_comb begin
    pcsel = aluresult;
    pcen  = pcwrite | (pcwritecond & zero);
    unique case (pcsrc_e'(pcsrc))
      PCSRC_ALU:    pcsel = aluresult;
      PCSRC_ALUOUT: pcsel = aluout;
      PCSRC_JUMP:   pcsel = jump_target(pc, instr);
      PCSRC_RSVD: begin
        pcsel = pc;
        pcen  = 1'b0;
      end
      default:      pcsel = aluresult;
    endcase
    // Every loaded PC is word aligned regardless of source
    pcnext = {pcsel[WIDTH-1:2], 2'b00};
  end

  flopenr #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pcen),
    .d     (pcnext),
    .q     (pc)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
    .clk   (clk),
    .reset (reset),
    .en    (irwrite),
    .d     (memrdata),
    .q     (instr)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (memrdata),
    .q     (mdr)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_aluout (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (aluresult),
    .q     (aluout)
  );

  // Address and opcode come only from registered state plus the iord select
  always_comb begin
    memaddr = iord ? aluout : pc;
    op      = instr[OP_HI:OP_LO];
  end

`ifdef PC_IR_PERF_COUNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instr_q;

  // Free-running cycle counter and fetched-instruction counter, both wrap at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (irwrite) begin
        instr_q <= instr_q + 32'd1;
      end
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed vector bench for pc_ir_unit.
// Latency: checks one clock after each applied vector.
// Backpressure: n/a.
module tb_pc_ir_unit;

  logic        clk;
  logic        reset;
  logic        pcwrite;
  logic        pcwritecond;
  logic        iord;
  logic        irwrite;
  logic [1:0]  pcsrc;
  logic        zero;
  logic [31:0] aluresult;
  logic [31:0] memrdata;
  logic [31:0] pc;
  logic [31:0] memaddr;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] mdr;
  logic [31:0] aluout;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  int checks;
  int errors;
  int cyc_model;
  int ins_model;

  pc_ir_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .irwrite     (irwrite),
    .pcsrc       (pcsrc),
    .zero        (zero),
    .aluresult   (aluresult),
    .memrdata    (memrdata),
    .pc          (pc),
    .memaddr     (memaddr),
    .instr       (instr),
    .op          (op),
    .mdr         (mdr),
    .aluout      (aluout),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pw;
    logic        pwc;
    logic        io;
    logic        irw;
    logic [1:0]  src;
    logic        z;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_aluout;
    logic [31:0] e_memaddr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cyc();
`ifdef PC_IR_PERF_COUNT_EN
    return 32'(cyc_model);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_ins();
`ifdef PC_IR_PERF_COUNT_EN
    return 32'(ins_model);
`else
    return 32'h0;
`endif
  endfunction

  // Drive one vector now (caller sits just after a falling edge), clock it, check, return after next falling edge
  task automatic apply(input vec_t v);
    pcwrite     = v.pw;
    pcwritecond = v.pwc;
    iord        = v.io;
    irwrite     = v.irw;
    pcsrc       = v.src;
    zero        = v.z;
    aluresult   = v.alu;
    memrdata    = v.mem;
    @(posedge clk);
    cyc_model++;
    if (v.irw) ins_model++;
    #1;
    chk({v.name, ".pc"},      pc,      v.e_pc);
    chk({v.name, ".instr"},   instr,   v.e_instr);
    chk({v.name, ".op"},      {26'd0, op}, {26'd0, v.e_instr[31:26]});
    chk({v.name, ".aluout"},  aluout,  v.e_aluout);
    chk({v.name, ".mdr"},     mdr,     v.mem);
    chk({v.name, ".memaddr"}, memaddr, v.e_memaddr);
    chk({v.name, ".cycles"},  cycle_count, exp_cyc());
    chk({v.name, ".instrs"},  instr_count, exp_ins());
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, ".pc"},      pc,          32'h0);
    chk({name, ".instr"},   instr,       32'h0);
    chk({name, ".op"},      {26'd0, op}, 32'h0);
    chk({name, ".mdr"},     mdr,         32'h0);
    chk({name, ".aluout"},  aluout,      32'h0);
    chk({name, ".memaddr"}, memaddr,     32'h0);
    chk({name, ".cycles"},  cycle_count, 32'h0);
    chk({name, ".instrs"},  instr_count, 32'h0);
  endtask

  initial begin
    vec_t f;
    checks = 0; errors = 0; cyc_model = 0; ins_model = 0;
    reset = 1'b1;
    pcwrite = 0; pcwritecond = 0; iord = 0; irwrite = 0;
    pcsrc = 2'b00; zero = 0; aluresult = 0; memrdata = 0;

    //        name       pw pwc io irw src   z  alu            mem            e_pc           e_instr        e_aluout       e_memaddr
    vecs[0]  = '{"fetch0",  1, 0, 0, 1, 2'b00, 0, 32'h0000_0004, 32'h8C01_0004, 32'h0000_0004, 32'h8C01_0004, 32'h0000_0004, 32'h0000_0004};
    vecs[1]  = '{"hold",    0, 0, 0, 0, 2'b00, 0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0004, 32'h8C01_0004, 32'h0000_0040, 32'h0000_0004};
    vecs[2]  = '{"brz0",    0, 1, 0, 0, 2'b01, 0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0004, 32'h8C01_0004, 32'h0000_0040, 32'h0000_0004};
    vecs[3]  = '{"brz1",    0, 1, 0, 0, 2'b01, 1, 32'h0000_0044, 32'h0000_0000, 32'h0000_0040, 32'h8C01_0004, 32'h0000_0044, 32'h0000_0040};
    vecs[4]  = '{"brpw",    1, 1, 0, 0, 2'b01, 0, 32'h0000_0080, 32'h0000_0000, 32'h0000_0044, 32'h8C01_0004, 32'h0000_0080, 32'h0000_0044};
    vecs[5]  = '{"fetchj",  1, 0, 0, 1, 2'b00, 0, 32'h1000_0004, 32'h0800_0010, 32'h1000_0004, 32'h0800_0010, 32'h1000_0004, 32'h1000_0004};
    vecs[6]  = '{"jump",    1, 0, 0, 0, 2'b10, 0, 32'h0000_0088, 32'h0000_0000, 32'h1000_0040, 32'h0800_0010, 32'h0000_0088, 32'h1000_0040};
    vecs[7]  = '{"iord",    0, 0, 1, 0, 2'b00, 0, 32'h0000_0088, 32'h0000_0000, 32'h1000_0040, 32'h0800_0010, 32'h0000_0088, 32'h0000_0088};
    vecs[8]  = '{"rsvd",    1, 0, 0, 0, 2'b11, 1, 32'h0000_0200, 32'h0000_0000, 32'h1000_0040, 32'h0800_0010, 32'h0000_0200, 32'h1000_0040};
    vecs[9]  = '{"align",   1, 0, 0, 0, 2'b00, 0, 32'h0000_8003, 32'h0000_0000, 32'h0000_8000, 32'h0800_0010, 32'h0000_8003, 32'h0000_8000};
    vecs[10] = '{"top",     1, 0, 0, 0, 2'b00, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0800_0010, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[11] = '{"wrap",    1, 0, 0, 1, 2'b00, 0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{"jump2",   1, 0, 0, 0, 2'b10, 0, 32'h0000_0000, 32'h0000_0000, 32'h08D1_59E0, 32'h1234_5678, 32'h0000_0000, 32'h08D1_59E0};
    vecs[13] = '{"rsvdc",   0, 1, 0, 0, 2'b11, 1, 32'h0000_0010, 32'h0000_0000, 32'h08D1_59E0, 32'h1234_5678, 32'h0000_0010, 32'h08D1_59E0};

    // Reset state while reset is held across an edge
    @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Ten more fetches, then an asynchronous reset in the middle of a low phase
    for (int i = 0; i < 10; i++) begin
      f = '{"loop", 1, 0, 0, 1, 2'b00, 0, 32'h0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      f.alu       = 32'(4 * (i + 1));
      f.mem       = 32'hAC00_0000 + 32'(i);
      f.e_pc      = f.alu;
      f.e_instr   = f.mem;
      f.e_aluout  = f.alu;
      f.e_memaddr = f.alu;
      apply(f);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("midrst");
    cyc_model = 0;
    ins_model = 0;
    @(negedge clk);
    reset = 1'b0;
    apply(vecs[0]);

`ifdef PC_IR_PERF_COUNT_EN
    // Preload the cycle counter near its limit and confirm it wraps to zero
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    @(posedge clk);
    #1;
    chk("cyc_wrap", cycle_count, 32'h0);
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
